gmux_ctrl: RTL and testbench

Sequencer that drives the SSEL select and per-quadrant enable controls of one global clock mux.
- Takes requests of the form "select source X, enable quadrant set M, static/dynamic mode".
- Applies each request glitch-free: gate all quadrants off, wait for drain, flip SSEL, wait for settle, then re-enable.
- Sits between configuration/power-management logic and the GMUX cell. Outputs wire straight to the GMUX control pins.

---
 rtl/gmux_ctrl_pkg.sv | 29 ++
 rtl/gmux_ctrl_if.sv | 24 ++
 rtl/gmux_ctrl_wait.sv | 26 ++
 rtl/gmux_ctrl.sv | 147 ++++++++++++++
 tb/tb_gmux_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/gmux_ctrl_pkg.sv
// rtl/gmux_ctrl_pkg.sv - shared types, constants and enable encoders for the GMUX sequencer
package gmux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int QUAD_TL = 3;
  localparam int QUAD_TR = 2;
  localparam int QUAD_BL = 1;
  localparam int QUAD_BR = 0;

  localparam logic SRC_GCLKIN = 1'b0;
  localparam logic SRC_HSCK   = 1'b1;

  localparam int CNT_W = 8;

  // Static quadrants take SEN, dynamic quadrants take DYNEN; DEN follows the mask in both modes.
  function automatic logic [3:0] sen_of(input logic [3:0] m, input logic d);
    return m & ~{4{d}};
  endfunction

  function automatic logic [3:0] dynen_of(input logic [3:0] m, input logic d);
    return m & {4{d}};
  endfunction

endpackage

// File: rtl/gmux_ctrl_if.sv
// rtl/gmux_ctrl_if.sv - request channel between configuration logic and the GMUX sequencer
interface gmux_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_sel;
  logic [3:0] req_qmask;
  logic       req_dyn;

  modport master (
    output req_valid,
    output req_sel,
    output req_qmask,
    output req_dyn,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    input  req_qmask,
    input  req_dyn,
    output req_ready
  );
endinterface

// File: rtl/gmux_ctrl_wait.sv
// rtl/gmux_ctrl_wait.sv - loadable down-counter timing the DRAIN and SETTLE states
module gmux_ctrl_wait
  import gmux_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gmux_ctrl.sv
// rtl/gmux_ctrl.sv - glitch-free SSEL/enable sequencer for one global clock mux
// Optional macro GMUX_CTRL_VLP_EN drives VLP low-power controls for unused quadrants.
module gmux_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC  = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gmux_ctrl_if.slave  req,
  output logic        ssel,
  output logic [3:0]  den,
  output logic [3:0]  sen,
  output logic [3:0]  dynen,
  output logic [3:0]  vlp,
  output logic        busy,
  output logic        done
);

  state_t           state, state_nxt;
  logic             ssel_nxt, busy_nxt, done_nxt;
  logic [3:0]       den_nxt, sen_nxt, dynen_nxt;
  logic [3:0]       m_q, m_nxt;
  logic             d_q, d_nxt;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             accept;

  assign req.req_ready = rst_n && (state == IDLE);
  assign accept        = req.req_valid && req.req_ready;

  gmux_ctrl_wait u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

`ifdef GMUX_CTRL_VLP_EN
  logic [3:0] vlp_nxt;
`endif

  always_comb begin
    state_nxt = state;
    ssel_nxt  = ssel;
    den_nxt   = den;
    sen_nxt   = sen;
    dynen_nxt = dynen;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    m_nxt     = m_q;
    d_nxt     = d_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
`ifdef GMUX_CTRL_VLP_EN
    vlp_nxt   = vlp;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          m_nxt = req.req_qmask;
          d_nxt = req.req_dyn;
          if (req.req_sel == ssel) begin
            // Same source: no glitch risk, so enables change in place.
            den_nxt   = req.req_qmask;
            sen_nxt   = sen_of(req.req_qmask, req.req_dyn);
            dynen_nxt = dynen_of(req.req_qmask, req.req_dyn);
            done_nxt  = 1'b1;
`ifdef GMUX_CTRL_VLP_EN
            vlp_nxt   = ~req.req_qmask;
`endif
          end else begin
            den_nxt   = '0;
            sen_nxt   = '0;
            dynen_nxt = '0;
            busy_nxt  = 1'b1;
            state_nxt = DRAIN;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(DRAIN_CYC - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          // Enables have been low for DRAIN_CYC cycles; SSEL may now flip safely.
          ssel_nxt  = ~ssel;
          state_nxt = SETTLE;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          den_nxt   = m_q;
          sen_nxt   = sen_of(m_q, d_q);
          dynen_nxt = dynen_of(m_q, d_q);
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`ifdef GMUX_CTRL_VLP_EN
          vlp_nxt   = ~m_q;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ssel  <= SRC_GCLKIN;
      den   <= '0;
      sen   <= '0;
      dynen <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      m_q   <= '0;
      d_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      ssel  <= ssel_nxt;
      den   <= den_nxt;
      sen   <= sen_nxt;
      dynen <= dynen_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      m_q   <= m_nxt;
      d_q   <= d_nxt;
    end
  end

`ifdef GMUX_CTRL_VLP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vlp <= '0;
    end else begin
      vlp <= vlp_nxt;
    end
  end
`else
  assign vlp = 4'h0;
`endif

endmodule

// File: tb/tb_gmux_ctrl.sv
// tb/tb_gmux_ctrl.sv - directed self-checking bench for gmux_ctrl
module tb_gmux_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ssel;
  logic [3:0] den, sen, dynen, vlp;
  logic       busy, done;
  int         checks;
  int         errors;
  logic       ssel_p;
  logic [3:0] en_p;

  gmux_ctrl_if rq ();

  gmux_ctrl #(.DRAIN_CYC(4), .SETTLE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq.slave),
    .ssel  (ssel),
    .den   (den),
    .sen   (sen),
    .dynen (dynen),
    .vlp   (vlp),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vx(input logic [3:0] m);
`ifdef GMUX_CTRL_VLP_EN
    return ~m;
`else
    return 4'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_ssel, input logic [3:0] e_den,
                         input logic [3:0] e_sen, input logic [3:0] e_dyn, input logic [3:0] e_vlp,
                         input logic e_busy, input logic e_done, input logic e_rdy);
    check({tag, ".ssel"},  ssel,         e_ssel);
    check({tag, ".den"},   den,          e_den);
    check({tag, ".sen"},   sen,          e_sen);
    check({tag, ".dynen"}, dynen,        e_dyn);
    check({tag, ".vlp"},   vlp,          e_vlp);
    check({tag, ".busy"},  busy,         e_busy);
    check({tag, ".done"},  done,         e_done);
    check({tag, ".ready"}, rq.req_ready, e_rdy);
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] m, input logic d);
    rq.req_valid = v;
    rq.req_sel   = s;
    rq.req_qmask = m;
    rq.req_dyn   = d;
  endtask

  // SSEL may only move while enables are low both before and after the change.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ssel_p !== 1'bx && ssel !== ssel_p)
      check("ssel_gated", {28'h0, den | sen | dynen | en_p}, 32'h0);
    ssel_p = ssel;
    en_p   = den | sen | dynen;
  end

  initial begin
    checks = 0;
    errors = 0;
    ssel_p = 1'bx;
    en_p   = 4'h0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0);

    // Reset held three cycles, then released
    repeat (3) tick();
    chk_out("rst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Same-source static request
    drive(1'b1, 1'b0, 4'b1010, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    chk_out("same_c1", 1'b0, 4'b1010, 4'b1010, 4'b0000, vx(4'b1010), 1'b0, 1'b1, 1'b1);
    tick();
    check("same_c2.done", done, 1'b0);

    // Source change with dynamic mode, default timing
    drive(1'b1, 1'b1, 4'b1111, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      chk_out($sformatf("chg_c%0d", c), (c >= 5), 4'h0, 4'h0, 4'h0, vx(4'b1010), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_out("chg_c9", 1'b1, 4'b1111, 4'b0000, 4'b1111, vx(4'b1111), 1'b0, 1'b1, 1'b1);

    // Held request with a differing payload while busy
    drive(1'b1, 1'b0, 4'b0101, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'b0011, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      chk_out($sformatf("hold_c%0d", c), (c < 5), 4'h0, 4'h0, 4'h0, vx(4'b1111), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_out("hold_c9", 1'b0, 4'b0101, 4'b0101, 4'b0000, vx(4'b0101), 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    chk_out("b2b_c1", 1'b0, 4'h0, 4'h0, 4'h0, vx(4'b0101), 1'b1, 1'b0, 1'b0);
    repeat (8) tick();
    chk_out("b2b_c9", 1'b1, 4'b0011, 4'b0000, 4'b0011, vx(4'b0011), 1'b0, 1'b1, 1'b1);

    // VLP must hold through the next full switch
    drive(1'b1, 1'b0, 4'b1111, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("vlp_hold_c%0d", c), vlp, vx(4'b0011));
      tick();
    end
    chk_out("vlp_c9", 1'b0, 4'b1111, 4'b1111, 4'b0000, vx(4'b1111), 1'b0, 1'b1, 1'b1);

    // Reset asserted in cycle 6 of a switch
    drive(1'b1, 1'b1, 4'b0110, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      chk_out($sformatf("abort_c%0d", c), (c >= 5), 4'h0, 4'h0, 4'h0, vx(4'b1111), 1'b1, 1'b0, 1'b0);
      if (c < 6) tick();
    end
    rst_n = 1'b0;
    tick();
    chk_out("abort_rst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_out($sformatf("abort_idle%0d", c), 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    end

    // Same-source dynamic request after the abort
    drive(1'b1, 1'b0, 4'b0001, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    chk_out("post_c1", 1'b0, 4'b0001, 4'b0000, 4'b0001, vx(4'b0001), 1'b0, 1'b1, 1'b1);

    // Empty mask source change
    drive(1'b1, 1'b1, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    chk_out("empty_c1", 1'b0, 4'h0, 4'h0, 4'h0, vx(4'b0001), 1'b1, 1'b0, 1'b0);
    repeat (8) tick();
    chk_out("empty_c9", 1'b1, 4'h0, 4'h0, 4'h0, vx(4'b0000), 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
